// File: rtl/addend_align_seq.sv
// ---------------------------------------------------------------------------
// addend_align_seq
//
// Purpose:
//    Sequential alignment of the product and addend significands ahead of a
//    fused multiply-add. One request is taken at a time. At accept the two
//    operands are pre-aligned into a common W-bit frame and an alignment
//    count is computed. The operand with the smaller exponent is then shifted
//    right by at most STEP bits per cycle, and every bit that falls off the
//    bottom is folded into that operand's sticky bit.
//
// Parameters:
//    NF    addend fraction bits (product significand is 2*NF+2 bits)
//    NE    exponent bits
//    STEP  maximum right shift applied per SHIFT cycle (1..W)
//
// Ports:
//    clk        rising-edge clock
//    reset      asynchronous active-high reset
//    in_valid   request valid
//    in_ready   high only in IDLE, when a request can be taken
//    mode       00 normal, 01 multiply underflow, 10 multiply overflow,
//               11 behaves as 00
//    p_frac     product significand, 2 integer bits
//    p_exp      product exponent, or under/overflow amount in modes 01/10
//    z          addend {exp, frac}; sign is handled elsewhere
//    z_nonzero  addend hidden bit
//    out_valid  aligned result valid, high only in DONE
//    out_ready  consumer accept
//    p_out      aligned product, W bits
//    z_out      aligned addend, W bits
//    p_acc      sticky OR of the bits shifted out of the product
//    z_acc      sticky OR of the bits shifted out of the addend
//    shift_cnt  saturated alignment count that was applied
// ---------------------------------------------------------------------------
module addend_align_seq #(
   parameter int NF   = 10,
   parameter int NE   = 5,
   parameter int STEP = 4,
   localparam int W   = 2*NF+3,
   localparam int CW  = $clog2(W+2)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [2*NF+1:0]  p_frac,
   input  logic [NE-1:0]    p_exp,
   input  logic [NE+NF-1:0] z,
   input  logic             z_nonzero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     p_out,
   output logic [W-1:0]     z_out,
   output logic             p_acc,
   output logic             z_acc,
   output logic [CW-1:0]    shift_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } stateT;

   stateT            state_q, state_d;
   logic [W-1:0]     pOpnd_q, pOpnd_d;
   logic [W-1:0]     zOpnd_q, zOpnd_d;
   logic             pAcc_q, pAcc_d;
   logic             zAcc_q, zAcc_d;
   logic             shiftP_q, shiftP_d;
   logic [CW-1:0]    shiftCnt_q, shiftCnt_d;
   logic [CW-1:0]    remain_q, remain_d;

   logic [NE-1:0]    zExp;
   logic [NF-1:0]    zFrac;
   logic [W-1:0]     pPre;
   logic [W-1:0]     zPre;

   logic [NE-1:0]    zEff;
   logic signed [NE+1:0] expDiff;
   logic [NE+1:0]    magnitude;
   logic [31:0]      magWide;
   logic             accShiftP;
   logic [CW-1:0]    accCount;

   logic [CW-1:0]    stepAmt;
   logic [W-1:0]     selOpnd;
   logic [W-1:0]     lostBits;
   logic [W-1:0]     shiftedOpnd;

   // Pre-alignment into the common W-bit frame. A product whose top integer
   // bit is clear is moved up one place so both layouts put the leading one
   // at the same position; the addend significand sits directly below the
   // guard zero with NF+1 zero bits underneath.
   always_comb begin
      zExp  = z[NE+NF-1:NF];
      zFrac = z[NF-1:0];
      if (p_frac[2*NF+1]) begin
         pPre = {1'b0, p_frac};
      end else begin
         pPre = {1'b0, p_frac[2*NF:0], 1'b0};
      end
      zPre = {1'b0, z_nonzero, zFrac, {(NF+1){1'b0}}};
   end

   // Alignment count and which operand gets shifted. In normal mode a zero
   // addend borrows the product exponent so nothing moves. Underflow always
   // shifts the product, overflow always shifts the addend. The magnitude is
   // held in NE+2 bits, which covers every sum or difference of two
   // exponents, and is then clamped to W+1 so an oversized count simply
   // empties the operand into its sticky bit.
   always_comb begin
      zEff      = z_nonzero ? zExp : p_exp;
      expDiff   = $signed({2'b00, p_exp}) - $signed({2'b00, zEff});
      magnitude = '0;
      accShiftP = 1'b0;
      case (mode)
         2'b01: begin
            accShiftP = 1'b1;
            magnitude = {2'b00, zExp} + {2'b00, p_exp};
         end
         2'b10: begin
            accShiftP = 1'b0;
            magnitude = {2'b00, {NE{1'b1}}} + {2'b00, p_exp} - {2'b00, zExp};
         end
         default: begin
            if (expDiff[NE+1]) begin
               accShiftP = 1'b1;
               magnitude = $unsigned(-expDiff);
            end else begin
               accShiftP = 1'b0;
               magnitude = $unsigned(expDiff);
            end
         end
      endcase
      magWide = {{(32-NE-2){1'b0}}, magnitude};
      if (magWide > 32'(W+1)) begin
         accCount = CW'(W+1);
      end else begin
         accCount = CW'(magWide);
      end
   end

   // One SHIFT cycle of work: move the selected operand right by the smaller
   // of STEP and what is left, and collect the bits that drop off the bottom.
   // A shift by the full width yields zero and a mask of all ones, so STEP=W
   // needs no special handling.
   always_comb begin
      if (32'(remain_q) > 32'(STEP)) begin
         stepAmt = CW'(STEP);
      end else begin
         stepAmt = remain_q;
      end
      selOpnd     = shiftP_q ? pOpnd_q : zOpnd_q;
      lostBits    = selOpnd & ~({W{1'b1}} << stepAmt);
      shiftedOpnd = selOpnd >> stepAmt;
   end

   // Next-state and handshake logic. Everything holds by default, so results
   // sitting in DONE stay put while the consumer stalls. The accept path
   // captures the pre-aligned operands and the count in one go, which is
   // what makes later input changes irrelevant. Returning from DONE lands in
   // IDLE, so a new request can only be taken on a later edge.
   always_comb begin
      state_d    = state_q;
      pOpnd_d    = pOpnd_q;
      zOpnd_d    = zOpnd_q;
      pAcc_d     = pAcc_q;
      zAcc_d     = zAcc_q;
      shiftP_d   = shiftP_q;
      shiftCnt_d = shiftCnt_q;
      remain_d   = remain_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pOpnd_d    = pPre;
               zOpnd_d    = zPre;
               pAcc_d     = 1'b0;
               zAcc_d     = 1'b0;
               shiftP_d   = accShiftP;
               shiftCnt_d = accCount;
               remain_d   = accCount;
               state_d    = (accCount != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (shiftP_q) begin
               pOpnd_d = shiftedOpnd;
               pAcc_d  = pAcc_q | (|lostBits);
            end else begin
               zOpnd_d = shiftedOpnd;
               zAcc_d  = zAcc_q | (|lostBits);
            end
            remain_d = remain_q - stepAmt;
            if (remain_q == stepAmt) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset clears everything at once, which
   // also drops out_valid and raises in_ready without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pOpnd_q    <= '0;
         zOpnd_q    <= '0;
         pAcc_q     <= 1'b0;
         zAcc_q     <= 1'b0;
         shiftP_q   <= 1'b0;
         shiftCnt_q <= '0;
         remain_q   <= '0;
      end else begin
         state_q    <= state_d;
         pOpnd_q    <= pOpnd_d;
         zOpnd_q    <= zOpnd_d;
         pAcc_q     <= pAcc_d;
         zAcc_q     <= zAcc_d;
         shiftP_q   <= shiftP_d;
         shiftCnt_q <= shiftCnt_d;
         remain_q   <= remain_d;
      end
   end

   assign p_out     = pOpnd_q;
   assign z_out     = zOpnd_q;
   assign p_acc     = pAcc_q;
   assign z_acc     = zAcc_q;
   assign shift_cnt = shiftCnt_q;

endmodule

// File: tb/tb_addend_align_seq.sv
// ---------------------------------------------------------------------------
// tb_addend_align_seq
//
// Purpose:
//    Self-checking bench for addend_align_seq at NF=10, NE=5, STEP=4.
//    Expected results are queued when a request is accepted and popped when
//    out_valid appears. Expectations come from hand-worked constants and from
//    a direct bit-level reference model of the alignment.
// ---------------------------------------------------------------------------
module tb_addend_align_seq;

   localparam int NF   = 10;
   localparam int NE   = 5;
   localparam int STEP = 4;
   localparam int W    = 2*NF+3;
   localparam int CW   = $clog2(W+2);

   typedef struct {
      logic [W-1:0]  pOut;
      logic [W-1:0]  zOut;
      logic          pAcc;
      logic          zAcc;
      logic [CW-1:0] cnt;
      int            lat;
   } expT;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       mode;
   logic [2*NF+1:0]  p_frac;
   logic [NE-1:0]    p_exp;
   logic [NE+NF-1:0] z;
   logic             z_nonzero;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     p_out;
   logic [W-1:0]     z_out;
   logic             p_acc;
   logic             z_acc;
   logic [CW-1:0]    shift_cnt;

   int  total;
   int  bad;
   expT sbQ[$];

   addend_align_seq #(.NF(NF), .NE(NE), .STEP(STEP)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .p_frac    (p_frac),
      .p_exp     (p_exp),
      .z         (z),
      .z_nonzero (z_nonzero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p_out     (p_out),
      .z_out     (z_out),
      .p_acc     (p_acc),
      .z_acc     (z_acc),
      .shift_cnt (shift_cnt)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build an expectation record from hand-worked values
   function automatic expT mkExp(input logic [W-1:0] pO, input logic [W-1:0] zO,
                                 input logic pA, input logic zA,
                                 input int cnt, input int lat);
      expT r;
      r.pOut = pO;
      r.zOut = zO;
      r.pAcc = pA;
      r.zAcc = zA;
      r.cnt  = CW'(cnt);
      r.lat  = lat;
      return r;
   endfunction

   // Reference model: integer exponent arithmetic, then a bit-at-a-time
   // sticky collection over the whole saturated shift distance.
   function automatic expT refModel(input logic [1:0] m, input logic [2*NF+1:0] pf,
                                    input logic [NE-1:0] pe, input logic [NE+NF-1:0] zz,
                                    input logic znz);
      expT        r;
      logic [W-1:0] pPre, zPre, v;
      int         zexp, pexp, ze, d, cnt, sat;
      bit         shP;
      logic       lost;
      zexp = int'(zz[NE+NF-1:NF]);
      pexp = int'(pe);
      pPre = pf[2*NF+1] ? {1'b0, pf} : {1'b0, pf[2*NF:0], 1'b0};
      zPre = {1'b0, znz, zz[NF-1:0], {(NF+1){1'b0}}};
      case (m)
         2'b01: begin shP = 1'b1; cnt = zexp + pexp; end
         2'b10: begin shP = 1'b0; cnt = 31 + pexp - zexp; end
         default: begin
            ze = znz ? zexp : pexp;
            d  = pexp - ze;
            if (d < 0) begin shP = 1'b1; cnt = -d; end
            else       begin shP = 1'b0; cnt = d;  end
         end
      endcase
      sat  = (cnt > W+1) ? W+1 : cnt;
      v    = shP ? pPre : zPre;
      lost = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i < sat) lost = lost | v[i];
      end
      v = (sat >= W) ? '0 : (v >> sat);
      r.pOut = shP ? v : pPre;
      r.zOut = shP ? zPre : v;
      r.pAcc = shP ? lost : 1'b0;
      r.zAcc = shP ? 1'b0 : lost;
      r.cnt  = CW'(sat);
      r.lat  = 1 + (sat + STEP - 1) / STEP;
      return r;
   endfunction

   // Drive one request, push its expectation at the accept edge, wait
   // (bounded) for the result, optionally stall the consumer, then retire.
   task automatic applyStimulus(input string tag, input logic [1:0] m,
                                input logic [2*NF+1:0] pf, input logic [NE-1:0] pe,
                                input logic [NE+NF-1:0] zz, input logic znz,
                                input expT e, input int holdCycles);
      expT           want;
      int            lat;
      logic [W-1:0]  capP, capZ;
      logic          capPA, capZA;
      logic [CW-1:0] capC;
      @(negedge clk);
      mode      = m;
      p_frac    = pf;
      p_exp     = pe;
      z         = zz;
      z_nonzero = znz;
      in_valid  = 1'b1;
      out_ready = (holdCycles > 0) ? 1'b0 : 1'b1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s in_ready_idle got=%b want=1", tag, in_ready);
      end
      @(posedge clk);
      sbQ.push_back(e);
      #1;
      in_valid  = 1'b0;
      mode      = 2'($urandom);
      p_frac    = (2*NF+2)'($urandom);
      p_exp     = NE'($urandom);
      z         = (NE+NF)'($urandom);
      z_nonzero = 1'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      want = sbQ.pop_front();
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s out_valid_timeout got=%b want=1 within 40 cycles", tag, out_valid);
         out_ready = 1'b1;
         return;
      end
      total++;
      if (lat !== want.lat) begin
         bad++;
         $display("[TB] FAIL %s latency got=%0d want=%0d", tag, lat, want.lat);
      end
      total++;
      if (p_out !== want.pOut) begin
         bad++;
         $display("[TB] FAIL %s p_out got=%h want=%h", tag, p_out, want.pOut);
      end
      total++;
      if (z_out !== want.zOut) begin
         bad++;
         $display("[TB] FAIL %s z_out got=%h want=%h", tag, z_out, want.zOut);
      end
      total++;
      if (p_acc !== want.pAcc) begin
         bad++;
         $display("[TB] FAIL %s p_acc got=%b want=%b", tag, p_acc, want.pAcc);
      end
      total++;
      if (z_acc !== want.zAcc) begin
         bad++;
         $display("[TB] FAIL %s z_acc got=%b want=%b", tag, z_acc, want.zAcc);
      end
      total++;
      if (shift_cnt !== want.cnt) begin
         bad++;
         $display("[TB] FAIL %s shift_cnt got=%0d want=%0d", tag, shift_cnt, want.cnt);
      end
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s in_ready_done got=%b want=0", tag, in_ready);
      end
      capP  = p_out;
      capZ  = z_out;
      capPA = p_acc;
      capZA = z_acc;
      capC  = shift_cnt;
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk);
         #1;
         total++;
         if ({p_out, z_out, p_acc, z_acc, shift_cnt, out_valid, in_ready} !==
             {capP, capZ, capPA, capZA, capC, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL %s hold_stable cycle=%0d got=%h/%h/%b/%b/%0d v=%b r=%b want=%h/%h/%b/%b/%0d v=1 r=0",
                     tag, i, p_out, z_out, p_acc, z_acc, shift_cnt, out_valid, in_ready,
                     capP, capZ, capPA, capZA, capC);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL %s retire got=v%b/r%b want=v0/r1", tag, out_valid, in_ready);
      end
   endtask

   // Reset state: outputs cleared and in_ready high while reset is held;
   // release lands just after an edge so the next edge can accept.
   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mode      = 2'b00;
      p_frac    = '0;
      p_exp     = '0;
      z         = '0;
      z_nonzero = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL reset_handshake got=r%b/v%b want=r1/v0", in_ready, out_valid);
      end
      total++;
      if ({p_out, z_out, p_acc, z_acc, shift_cnt} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%h/%h/%b/%b/%0d want=all zero",
                  p_out, z_out, p_acc, z_acc, shift_cnt);
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // Hand-worked scenarios, the first accepted on the first edge after reset
   task automatic test_directed();
      applyStimulus("z_by_3", 2'b00, 22'h200000, 5'd15, {5'd12, 10'h000}, 1'b1,
                    mkExp(23'h200000, 23'h040000, 1'b0, 1'b0, 3, 2), 0);
      applyStimulus("equal_exp", 2'b00, 22'h155555, 5'd15, {5'd15, 10'h2AB}, 1'b1,
                    mkExp(23'h2AAAAA, 23'h355800, 1'b0, 1'b0, 0, 1), 0);
      applyStimulus("p_saturate", 2'b00, 22'h200001, 5'd2, {5'd30, 10'h000}, 1'b1,
                    mkExp(23'h000000, 23'h200000, 1'b1, 1'b0, 24, 7), 0);
      applyStimulus("z_by_12_sticky", 2'b00, 22'h200000, 5'd20, {5'd8, 10'h001}, 1'b1,
                    mkExp(23'h200000, 23'h000200, 1'b0, 1'b1, 12, 4), 0);
      applyStimulus("mode10", 2'b10, 22'h3ABCDE, 5'd1, {5'd30, 10'h3FF}, 1'b1,
                    mkExp(23'h3ABCDE, 23'h0FFE00, 1'b0, 1'b0, 2, 2), 0);
      applyStimulus("mode01", 2'b01, 22'h2000FF, 5'd3, {5'd2, 10'h155}, 1'b1,
                    mkExp(23'h010007, 23'h2AA800, 1'b1, 1'b0, 5, 3), 0);
      applyStimulus("mode11_as_00", 2'b11, 22'h200000, 5'd15, {5'd12, 10'h000}, 1'b1,
                    mkExp(23'h200000, 23'h040000, 1'b0, 1'b0, 3, 2), 0);
      applyStimulus("z_zero", 2'b00, 22'h300000, 5'd9, {5'd27, 10'h0F0}, 1'b0,
                    mkExp(23'h300000, 23'h078000, 1'b0, 1'b0, 0, 1), 0);
   endtask

   // Randomised requests issued back to back against the reference model
   task automatic test_back_to_back();
      logic [1:0]       m;
      logic [2*NF+1:0]  pf;
      logic [NE-1:0]    pe;
      logic [NE+NF-1:0] zz;
      logic             znz;
      for (int i = 0; i < 16; i++) begin
         m   = 2'($urandom_range(0, 3));
         pf  = (2*NF+2)'($urandom);
         pe  = NE'($urandom);
         zz  = (NE+NF)'($urandom);
         znz = (i % 5 == 4) ? 1'b0 : 1'b1;
         applyStimulus("random", m, pf, pe, zz, znz, refModel(m, pf, pe, zz, znz), 0);
      end
   endtask

   // Consumer stall for 5 cycles in DONE, then reset in the middle of a
   // following long shift: outputs clear at once and no result appears.
   task automatic test_backpressure_reset();
      bit seen;
      applyStimulus("backpressure", 2'b00, 22'h200000, 5'd20, {5'd8, 10'h001}, 1'b1,
                    mkExp(23'h200000, 23'h000200, 1'b0, 1'b1, 12, 4), 5);
      @(negedge clk);
      mode      = 2'b00;
      p_frac    = 22'h200001;
      p_exp     = 5'd2;
      z         = {5'd30, 10'h000};
      z_nonzero = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL midshift_reset_handshake got=r%b/v%b want=r1/v0", in_ready, out_valid);
      end
      total++;
      if ({p_out, z_out, p_acc, z_acc, shift_cnt} !== '0) begin
         bad++;
         $display("[TB] FAIL midshift_reset_outputs got=%h/%h/%b/%b/%0d want=all zero",
                  p_out, z_out, p_acc, z_acc, shift_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("[TB] FAIL discarded_op out_valid_seen got=%b want=0", seen);
      end
      applyStimulus("after_reset", 2'b00, 22'h200000, 5'd15, {5'd12, 10'h000}, 1'b1,
                    mkExp(23'h200000, 23'h040000, 1'b0, 1'b0, 3, 2), 0);
   endtask

   // Final tally
   task automatic checkOutput();
      total++;
      if (sbQ.size() !== 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sbQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
   endtask

   // Scenario sequence
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure_reset();
      checkOutput();
      $finish;
   end

endmodule
